// File: rtl/mem_pkg.sv
// Shared types and encodings for the CPU-side memory responder.
package mem_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE0, S_ISSUE1, S_CAP, S_DONE} state_t;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_WORD = 2'b01;
  localparam logic [1:0] MW_BYTE = 2'b10;

  localparam logic DTYPE_DW = 1'b1;
  localparam logic DTYPE_W  = 1'b0;
endpackage

// File: rtl/mem_responder_if.sv
// CPU request/response bundle; master is the CPU, slave is the responder.
interface mem_responder_if #(parameter int N = 64);
  logic [N-1:0] dataadr;
  logic [N-1:0] writedata;
  logic [1:0]   memwrite;
  logic         memrd;
  logic         dtype;
  logic [N-1:0] readdata;
  logic         memready;
  logic         busy;
  logic         misalign;

  modport master (output dataadr, writedata, memwrite, memrd, dtype,
                  input  readdata, memready, busy, misalign);
  modport slave  (input  dataadr, writedata, memwrite, memrd, dtype,
                  output readdata, memready, busy, misalign);
endinterface

// File: rtl/mem_lane.sv
// Byte-enable and write-data lane steering for one SRAM beat (combinational).
module mem_lane
  import mem_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [1:0]   kind,
  input  logic         dtype,
  input  logic [1:0]   adr_lo,
  input  logic         beat,
  input  logic [N-1:0] writedata,
  output logic [3:0]   be,
  output logic [31:0]  wdata
);
  always_comb begin
    be    = 4'b1111;
    wdata = writedata[31:0];
    if (kind == MW_BYTE) begin
      be    = 4'b0001 << adr_lo;
      wdata = {4{writedata[7:0]}};
    end else if (dtype == DTYPE_DW && beat) begin
      wdata = writedata[63:32];
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Serves CPU loads/stores from a 32-bit synchronous SRAM, doublewords in two beats.
// Alignment checking is compiled in with MEMRESP_ALIGN_CHK_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int N  = 64,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave cpu,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  input  logic [31:0]   sram_rdata
);
  state_t        state, state_nxt;
  logic [AW+1:0] adr_q;
  logic [N-1:0]  wdat_q;
  logic [1:0]    kind_q;
  logic          dw_q, wr_q, bad_q;
  logic [N-1:0]  readdata_q;
  logic          misalign_q;

  logic          req, dw_in, bad_in, issue, beat;
  logic [1:0]    kind_in;
  logic [AW-1:0] w0, w1;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic          unused_adr;

  assign unused_adr = ^cpu.dataadr[N-1:AW+2];

  // 11 behaves as 01; a simultaneous read is dropped in favour of the write.
  assign kind_in = (cpu.memwrite == MW_BYTE) ? MW_BYTE :
                   (cpu.memwrite != MW_NONE) ? MW_WORD : MW_NONE;
  assign req     = cpu.memrd || (cpu.memwrite != MW_NONE);
  assign dw_in   = (cpu.dtype == DTYPE_DW) && (kind_in != MW_BYTE);

`ifdef MEMRESP_ALIGN_CHK_EN
  assign bad_in = dw_in ? (|cpu.dataadr[2:0])
                        : ((kind_in != MW_BYTE) && (|cpu.dataadr[1:0]));
`else
  assign bad_in = 1'b0;
`endif

  assign w0 = dw_q ? {adr_q[AW+1:3], 1'b0} : adr_q[AW+1:2];
  assign w1 = w0 + {{(AW-1){1'b0}}, 1'b1};

  mem_lane #(.N(N)) u_lane (
    .kind      (kind_q),
    .dtype     (dw_q),
    .adr_lo    (adr_q[1:0]),
    .beat      (beat),
    .writedata (wdat_q),
    .be        (lane_be),
    .wdata     (lane_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      adr_q      <= '0;
      wdat_q     <= '0;
      kind_q     <= MW_NONE;
      dw_q       <= 1'b0;
      wr_q       <= 1'b0;
      bad_q      <= 1'b0;
      readdata_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req) begin
        adr_q  <= cpu.dataadr[AW+1:0];
        wdat_q <= cpu.writedata;
        kind_q <= kind_in;
        dw_q   <= dw_in;
        wr_q   <= (kind_in != MW_NONE);
        bad_q  <= bad_in;
        if (bad_in) misalign_q <= 1'b1;
      end
      // SRAM data lags the address by one cycle, so beats land in ISSUE1/CAP.
      if (state == S_ISSUE1 && !wr_q) readdata_q[31:0] <= sram_rdata;
      if (state == S_CAP) begin
        if (dw_q) readdata_q[63:32] <= sram_rdata;
        else      readdata_q        <= {{(N-32){1'b0}}, sram_rdata};
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    beat       = 1'b0;
    sram_addr  = '0;
    sram_we    = 1'b0;
    sram_be    = 4'b0000;
    sram_wdata = '0;
    case (state)
      S_IDLE:   if (req) state_nxt = S_ISSUE0;
      S_ISSUE0: begin
        issue     = 1'b1;
        sram_addr = w0;
        state_nxt = dw_q ? S_ISSUE1 : (wr_q ? S_DONE : S_CAP);
      end
      S_ISSUE1: begin
        issue     = 1'b1;
        beat      = 1'b1;
        sram_addr = w1;
        state_nxt = wr_q ? S_DONE : S_CAP;
      end
      S_CAP:    state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (issue && wr_q) begin
      sram_we    = !bad_q;
      sram_be    = lane_be;
      sram_wdata = lane_wdata;
    end
  end

  assign cpu.readdata = readdata_q;
  assign cpu.memready = (state == S_DONE);
  assign cpu.busy     = (state != S_IDLE);
  assign cpu.misalign = misalign_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a behavioural 32-bit synchronous SRAM.
module tb_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_clr;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        sram_we;
  logic [3:0]  sram_be;
  logic [31:0] mem [0:4095];
  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  int          checks = 0;
  int          errors = 0;
  int          lat;

  mem_responder_if #(.N(64)) cpu ();

  mem_responder #(.N(64), .AW(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (cpu),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'hDEAD_0000 + i;
    end else if (sram_we) begin
      for (int b = 0; b < 4; b++)
        if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
    sram_rdata <= mem[sram_addr];
  end

  always @(negedge clk) begin
    if (sram_we) begin
      last_be    <= sram_be;
      last_wdata <= sram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Returns at the negedge of the DONE cycle; lat counts cycles from acceptance (0 = never finished).
  task automatic do_req(input logic [63:0] adr, input logic [63:0] wd, input logic [1:0] mw,
                        input logic rd, input logic dt, output int l);
    @(negedge clk);
    cpu.dataadr   = adr;
    cpu.writedata = wd;
    cpu.memwrite  = mw;
    cpu.memrd     = rd;
    cpu.dtype     = dt;
    @(posedge clk);
    l = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cpu.memready) begin
        l = k;
        break;
      end
    end
    cpu.memwrite = MW_NONE;
    cpu.memrd    = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    mem_clr       = 1'b1;
    cpu.dataadr   = '0;
    cpu.writedata = '0;
    cpu.memwrite  = MW_NONE;
    cpu.memrd     = 1'b0;
    cpu.dtype     = DTYPE_W;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_readdata", cpu.readdata, 64'h0);
    chk("rst_memready", cpu.memready, 0);
    chk("rst_busy", cpu.busy, 0);
    chk("rst_misalign", cpu.misalign, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_be", sram_be, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    mem_clr = 1'b0;
    reset   = 1'b1;

    do_req(64'h40, 64'h1122_3344_5566_7788, MW_WORD, 1'b0, DTYPE_DW, lat);
    chk("dw_wr_lat", lat, 3);
    chk("dw_wr_lo", mem[12'h010], 32'h5566_7788);
    chk("dw_wr_hi", mem[12'h011], 32'h1122_3344);

    do_req(64'h40, 64'h0, MW_NONE, 1'b1, DTYPE_DW, lat);
    chk("dw_rd_lat", lat, 4);
    chk("dw_rd_data", cpu.readdata, 64'h1122_3344_5566_7788);

    do_req(64'h44, 64'h0, MW_NONE, 1'b1, DTYPE_W, lat);
    chk("w_rd_lat", lat, 3);
    chk("w_rd_data", cpu.readdata, 64'h0000_0000_1122_3344);

    do_req(64'h42, 64'hAB, MW_BYTE, 1'b0, DTYPE_W, lat);
    chk("b_wr_lat", lat, 2);
    chk("b_wr_be", last_be, 4'b0100);
    chk("b_wr_wdata", last_wdata, 32'hABAB_ABAB);
    chk("b_wr_keep_rd", cpu.readdata, 64'h0000_0000_1122_3344);

    do_req(64'h40, 64'h0, MW_NONE, 1'b1, DTYPE_W, lat);
    chk("b_rd_back", cpu.readdata, 64'h0000_0000_55AB_7788);

    do_req(64'h0000_0001_0000_0044, 64'h0, MW_NONE, 1'b1, DTYPE_W, lat);
    chk("hi_adr_lat", lat, 3);
    chk("hi_adr_data", cpu.readdata, 64'h0000_0000_1122_3344);

    do_req(64'h48, 64'h0000_0000_9988_7766, MW_WORD, 1'b1, DTYPE_W, lat);
    chk("rw_lat", lat, 2);
    chk("rw_mem", mem[12'h012], 32'h9988_7766);
    chk("rw_keep_rd", cpu.readdata, 64'h0000_0000_1122_3344);

    do_req(64'h3FFC, 64'hCAFE_F00D_1234_5678, MW_WORD, 1'b0, DTYPE_DW, lat);
    chk("top_wr_lat", lat, 3);
    chk("top_wr_lo", mem[12'hFFE], 32'h1234_5678);
    chk("top_wr_hi", mem[12'hFFF], 32'hCAFE_F00D);
    chk("top_wr_w0", mem[12'h000], 32'hDEAD_0000);

    do_req(64'h3FF8, 64'h0, MW_NONE, 1'b1, DTYPE_DW, lat);
    chk("top_rd_data", cpu.readdata, 64'hCAFE_F00D_1234_5678);

    do_req(64'h3FFC, 64'h0BAD_C0DE, MW_WORD, 1'b0, DTYPE_W, lat);
    chk("top_w_mem", mem[12'hFFF], 32'h0BAD_C0DE);
    chk("top_w_w0", mem[12'h000], 32'hDEAD_0000);

    @(negedge clk);
    cpu.dataadr   = 64'h80;
    cpu.writedata = 64'hAAAA_AAAA_BBBB_BBBB;
    cpu.memwrite  = MW_WORD;
    cpu.dtype     = DTYPE_DW;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    cpu.memwrite = MW_NONE;
    #1;
    chk("mid_rst_busy", cpu.busy, 0);
    chk("mid_rst_we", sram_we, 0);
    chk("mid_rst_addr", sram_addr, 0);
    chk("mid_rst_be", sram_be, 0);
    chk("mid_rst_wdata", sram_wdata, 0);
    chk("mid_rst_rd", cpu.readdata, 64'h0);
    chk("mid_rst_rdy", cpu.memready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_beat0", mem[12'h020], 32'hBBBB_BBBB);
    chk("mid_rst_beat1", mem[12'h021], 32'hDEAD_0021);
    chk("mid_rst_idle", cpu.busy, 0);

    do_req(64'h41, 64'h7777_7777, MW_WORD, 1'b0, DTYPE_W, lat);
    chk("mis_lat", lat, 2);
`ifdef MEMRESP_ALIGN_CHK_EN
    chk("mis_flag", cpu.misalign, 1);
    chk("mis_no_wr", mem[12'h010], 32'h55AB_7788);
    @(negedge clk);
    chk("mis_sticky", cpu.misalign, 1);
`else
    chk("mis_flag", cpu.misalign, 0);
    chk("mis_trunc_wr", mem[12'h010], 32'h7777_7777);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
